// File: rtl/lcd_seq.sv
// Two-requester LCD write sequencer: round-robin grant, then poll the LCD ready
// bit, write up to five message words and one instruction word over Wishbone.
module lcd_seq #(
   parameter logic [31:0] BASE_ADR     = 32'hF001_0000,
   parameter int unsigned POLL_TIMEOUT = 65535
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req_i,
   input  logic [159:0] msg0_i,
   input  logic [159:0] msg1_i,
   input  logic [1:0]   ins0_i,
   input  logic [1:0]   ins1_i,
   output logic [1:0]   gnt_o,
   output logic [1:0]   done_o,
   output logic [1:0]   err_o,
   output logic         busy_o,
   output logic         wb_cyc_o,
   output logic         wb_stb_o,
   output logic         wb_we_o,
   output logic [31:0]  wb_adr_o,
   output logic [3:0]   wb_sel_o,
   output logic [31:0]  wb_dat_o,
   input  logic [31:0]  wb_dat_i,
   input  logic         wb_ack_i
);

   // state    | meaning
   // IDLE     | waiting for a request, arbitrates round-robin
   // POLL     | reading the status word until the ready bit is set
   // WR_DATA  | writing the five captured message words
   // WR_INS   | writing the instruction word (clear / change-row)
   // FIN      | done pulse, back to IDLE next cycle
   typedef enum logic [2:0] {ST_IDLE, ST_POLL, ST_WR_DATA, ST_WR_INS, ST_FIN} state_t;

   localparam logic [31:0] TMO_LAST = 32'(POLL_TIMEOUT - 1);

   state_t         state_q, state_d;
   logic           last_q, last_d;
   logic           cur_q, cur_d;
   logic [1:0]     gnt_q, gnt_d;
   logic [159:0]   msg_q, msg_d;
   logic           clr_q, clr_d;
   logic           chrow_q, chrow_d;
   logic [2:0]     idx_q, idx_d;
   logic [31:0]    tmo_q, tmo_d;
   logic           stb_q, stb_d;
   logic           we_q, we_d;
   logic [31:0]    adr_q, adr_d;
   logic [3:0]     sel_q, sel_d;
   logic [31:0]    dat_q, dat_d;
   logic [1:0]     done_q, done_d;
   logic [1:0]     err_q, err_d;

   logic           launch;
   logic           l_we;
   logic [31:0]    l_adr;
   logic [31:0]    l_dat;
   logic           win;
   logic           unused_dat;

   assign unused_dat = ^wb_dat_i[31:1];

   function automatic logic [31:0] msg_word(input logic [159:0] m, input logic [2:0] i);
      case (i)
         3'd0:    msg_word = m[159:128];
         3'd1:    msg_word = m[127:96];
         3'd2:    msg_word = m[95:64];
         3'd3:    msg_word = m[63:32];
         default: msg_word = m[31:0];
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cur_d   = cur_q;
      gnt_d   = gnt_q;
      msg_d   = msg_q;
      clr_d   = clr_q;
      chrow_d = chrow_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      stb_d   = stb_q;
      we_d    = we_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      done_d  = 2'b00;
      err_d   = 2'b00;
      launch  = 1'b0;
      l_we    = 1'b0;
      l_adr   = BASE_ADR;
      l_dat   = 32'd0;
      win     = 1'b0;

      // A new transfer is only launched while stb is low, which yields the
      // one-cycle idle gap between back-to-back transfers.
      case (state_q)
         ST_IDLE: begin
            if (req_i != 2'b00) begin
               win              = (req_i == 2'b11) ? ~last_q : req_i[1];
               cur_d            = win;
               gnt_d            = win ? 2'b10 : 2'b01;
               msg_d            = win ? msg1_i : msg0_i;
               {chrow_d, clr_d} = win ? ins1_i : ins0_i;
               tmo_d            = 32'd0;
               state_d          = ST_POLL;
               launch           = 1'b1;
            end
         end
         ST_POLL: begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_q == TMO_LAST) begin
               stb_d   = 1'b0;
               err_d   = gnt_q;
               gnt_d   = 2'b00;
               state_d = ST_IDLE;
            end else if (!stb_q) begin
               launch = 1'b1;
            end else if (wb_ack_i) begin
               stb_d = 1'b0;
               if (wb_dat_i[0]) begin
                  idx_d   = 3'd0;
                  state_d = clr_q ? ST_WR_INS : ST_WR_DATA;
               end
            end
         end
         ST_WR_DATA: begin
            if (!stb_q) begin
               launch = 1'b1;
               l_we   = 1'b1;
               l_adr  = BASE_ADR + 32'd4 + {27'd0, idx_q, 2'b00};
               l_dat  = msg_word(msg_q, idx_q);
            end else if (wb_ack_i) begin
               stb_d = 1'b0;
               if (idx_q == 3'd4) state_d = ST_WR_INS;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         ST_WR_INS: begin
            if (!stb_q) begin
               launch = 1'b1;
               l_we   = 1'b1;
               l_adr  = BASE_ADR + 32'h18;
               l_dat  = {27'd0, chrow_q, 2'b00, clr_q, ~clr_q};
            end else if (wb_ack_i) begin
               stb_d   = 1'b0;
               done_d  = gnt_q;
               gnt_d   = 2'b00;
               last_d  = cur_q;
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
         stb_d = 1'b1;
         we_d  = l_we;
         adr_d = l_adr;
         sel_d = 4'hF;
         dat_d = l_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         cur_q   <= 1'b0;
         gnt_q   <= 2'b00;
         msg_q   <= '0;
         clr_q   <= 1'b0;
         chrow_q <= 1'b0;
         idx_q   <= 3'd0;
         tmo_q   <= 32'd0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 32'd0;
         sel_q   <= 4'h0;
         dat_q   <= 32'd0;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cur_q   <= cur_d;
         gnt_q   <= gnt_d;
         msg_q   <= msg_d;
         clr_q   <= clr_d;
         chrow_q <= chrow_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign gnt_o    = gnt_q;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign busy_o   = (state_q != ST_IDLE);
   assign wb_cyc_o = stb_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_sel_o = sel_q;
   assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_lcd_seq.sv
// Bench for lcd_seq: a behavioural Wishbone slave logs every transfer and a
// transaction-level model predicts the transfer stream, grant order and pulses.
module tb_lcd_seq;

   localparam logic [31:0] BASE = 32'hF001_0000;
   localparam int          TMO  = 20;

   typedef struct packed {
      logic        who;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } xfer_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req_i;
   logic [159:0] msg0_i, msg1_i;
   logic [1:0]   ins0_i, ins1_i;
   logic [1:0]   gnt_o, done_o, err_o;
   logic         busy_o;
   logic         wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0]  wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]   wb_sel_o;
   logic         wb_ack_i;

   lcd_seq #(.BASE_ADR(BASE), .POLL_TIMEOUT(TMO)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req_i),
      .msg0_i   (msg0_i),
      .msg1_i   (msg1_i),
      .ins0_i   (ins0_i),
      .ins1_i   (ins1_i),
      .gnt_o    (gnt_o),
      .done_o   (done_o),
      .err_o    (err_o),
      .busy_o   (busy_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_sel_o (wb_sel_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc_n = 0;
   xfer_t        log_q[$];
   xfer_t        exp_q[$];
   int           gnt_order[$];
   int           gnt_cyc [2];
   int           done_cyc[2];
   int           err_cyc [2];
   int           done_cnt[2];
   int           err_cnt [2];
   int           bad_bus = 0;
   int           bad_gap = 0;
   int           stray = 0;
   int           nr_cfg[2];
   logic [159:0] msg_cfg[2];
   logic [1:0]   ins_cfg[2];
   int           slave_delay = -1;
   int           model_last = 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [159:0] rand_msg();
      logic [159:0] m;
      for (int w = 0; w < 5; w++) m[32*w +: 32] = $urandom();
      return m;
   endfunction

   // Slave + monitor: samples 1 time unit after each rising edge.
   initial begin : slave_mon
      logic [1:0]  prev_gnt;
      logic        in_xfer;
      logic [31:0] rnd;
      int          wait_n, low_run, seq_xfers, reads_seq, cur;
      xfer_t       cur_x;
      prev_gnt = 2'b00; in_xfer = 1'b0; wait_n = 0; low_run = 0;
      seq_xfers = 0; reads_seq = 0; cur = 0; cur_x = '0;
      wb_ack_i = 1'b0; wb_dat_i = 32'd0;
      forever begin
         @(posedge clk); #1;
         cyc_n++;
         if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
            cur = gnt_o[1] ? 1 : 0;
            if ($countones(gnt_o) != 1) bad_bus++;
            gnt_order.push_back(cur);
            gnt_cyc[cur] = cyc_n;
            seq_xfers = 0;
            reads_seq = 0;
         end
         prev_gnt = gnt_o;
         for (int r = 0; r < 2; r++) begin
            if (done_o[r]) begin done_cnt[r]++; done_cyc[r] = cyc_n; end
            if (err_o[r])  begin err_cnt[r]++;  err_cyc[r]  = cyc_n; end
         end
         if (!wb_stb_o) begin
            wb_ack_i = 1'b0;
            in_xfer  = 1'b0;
            low_run++;
            if (wb_cyc_o) bad_bus++;
         end else begin
            if (!wb_cyc_o || wb_sel_o != 4'hF) bad_bus++;
            if (!in_xfer) begin
               in_xfer = 1'b1;
               if (seq_xfers > 0 && low_run != 1) bad_gap++;
               low_run = 0;
               seq_xfers++;
               if (gnt_o == 2'b00) stray++;
               cur_x = '{who: 1'(cur), we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o};
               log_q.push_back(cur_x);
               wait_n = (slave_delay < 0) ? $urandom_range(0, 2) : slave_delay;
               rnd = $urandom();
               if (!wb_we_o) begin
                  wb_dat_i = {rnd[31:1], (reads_seq >= nr_cfg[cur])};
                  reads_seq++;
               end else begin
                  wb_dat_i = rnd;
               end
            end else if (wb_we_o != cur_x.we || wb_adr_o != cur_x.adr || wb_dat_o != cur_x.dat) begin
               bad_bus++;
            end
            if (wait_n == 0) wb_ack_i = 1'b1;
            else             wait_n--;
         end
      end
   end

   // Transaction-level expectation for one granted sequence.
   task automatic model_seq(input int r);
      xfer_t        x;
      logic [159:0] m;
      logic [1:0]   ins;
      m = msg_cfg[r];
      ins = ins_cfg[r];
      for (int k = 0; k <= nr_cfg[r]; k++) begin
         x = '{who: 1'(r), we: 1'b0, adr: BASE, dat: 32'd0};
         exp_q.push_back(x);
      end
      if (!ins[0]) begin
         for (int i = 0; i < 5; i++) begin
            x = '{who: 1'(r), we: 1'b1, adr: BASE + 32'(4 * (i + 1)), dat: 32'(m >> (32 * (4 - i)))};
            exp_q.push_back(x);
         end
      end
      x = '{who: 1'(r), we: 1'b1, adr: BASE + 32'h18,
            dat: (ins[1] ? 32'd16 : 32'd0) + (ins[0] ? 32'd2 : 32'd1)};
      exp_q.push_back(x);
   endtask

   task automatic run_seq(input logic [1:0] who, input logic [1:0] drop_early,
                          input bit expect_err, input bit glitch1);
      logic [1:0] fin;
      int         first, second, g_cnt, n_wr;
      log_q.delete(); exp_q.delete(); gnt_order.delete();
      done_cnt = '{0, 0}; err_cnt = '{0, 0};
      err_cyc = '{-1000, -1000}; done_cyc = '{-1000, -1000};
      bad_bus = 0; bad_gap = 0; stray = 0; g_cnt = 0;
      msg0_i = msg_cfg[0]; msg1_i = msg_cfg[1];
      ins0_i = ins_cfg[0]; ins1_i = ins_cfg[1];
      first  = (who == 2'b11) ? ((model_last == 1) ? 0 : 1) : (who[1] ? 1 : 0);
      second = 1 - first;
      model_seq(first);
      if (who == 2'b11) model_seq(second);
      req_i = who;
      fin = 2'b00;
      for (int c = 0; c < 400 && fin != who; c++) begin
         @(posedge clk); #2;
         if (glitch1) begin
            if (gnt_o[0] && g_cnt < 3) begin req_i[1] = 1'b1; g_cnt++; end
            else req_i[1] = 1'b0;
         end
         for (int r = 0; r < 2; r++) begin
            if (done_o[r] || err_o[r]) begin
               fin[r] = 1'b1;
               req_i[r] = 1'b0;
            end else if (gnt_o[r]) begin
               if (r == 0) begin msg0_i = rand_msg(); ins0_i = 2'($urandom()); end
               else        begin msg1_i = rand_msg(); ins1_i = 2'($urandom()); end
               if (drop_early[r]) req_i[r] = 1'b0;
            end
         end
      end
      check_eq("seq_complete", fin, who);
      if (expect_err) begin
         @(posedge clk); #2;
         check_eq("busy_after_err", busy_o, 1'b0);
      end
      repeat (3) @(posedge clk);
      #2;
      if (expect_err) begin
         n_wr = 0;
         foreach (log_q[i]) if (log_q[i].we || log_q[i].adr != BASE) n_wr++;
         check_eq("tmo_no_write", n_wr, 0);
         check_eq("tmo_err_lat", err_cyc[first] - gnt_cyc[first], TMO);
      end else begin
         check_eq("n_xfers", log_q.size(), exp_q.size());
         for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("x%0d_who", i), log_q[i].who, exp_q[i].who);
            check_eq($sformatf("x%0d_we", i),  log_q[i].we,  exp_q[i].we);
            check_eq($sformatf("x%0d_adr", i), log_q[i].adr, exp_q[i].adr);
            if (exp_q[i].we) check_eq($sformatf("x%0d_dat", i), log_q[i].dat, exp_q[i].dat);
         end
      end
      check_eq("n_grants", gnt_order.size(), (who == 2'b11) ? 2 : 1);
      if (gnt_order.size() > 0) check_eq("grant0", gnt_order[0], first);
      if (who == 2'b11 && gnt_order.size() > 1) check_eq("grant1", gnt_order[1], second);
      for (int r = 0; r < 2; r++) begin
         check_eq($sformatf("done_cnt%0d", r), done_cnt[r], (who[r] && !expect_err) ? 1 : 0);
         check_eq($sformatf("err_cnt%0d", r),  err_cnt[r],  (who[r] &&  expect_err) ? 1 : 0);
      end
      check_eq("bus_rules", bad_bus, 0);
      check_eq("gap_one", bad_gap, 0);
      check_eq("stray_xfer", stray, 0);
      if (!expect_err) model_last = (who == 2'b11) ? second : first;
   endtask

   initial begin
      logic hit;
      reset = 1'b0; req_i = 2'b00;
      msg0_i = '0; msg1_i = '0; ins0_i = 2'b00; ins1_i = 2'b00;
      nr_cfg = '{0, 0}; ins_cfg = '{2'b00, 2'b00};
      msg_cfg[0] = '0; msg_cfg[1] = '0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, gnt_o, done_o, err_o, busy_o}, 0);
      check_eq("rst_adr", wb_adr_o, 0);
      check_eq("rst_dat", wb_dat_o, 0);
      reset = 1'b1;
      @(posedge clk); #2;

      // simultaneous requests, twice: 0 then 1 each time
      for (int p = 0; p < 2; p++) begin
         for (int r = 0; r < 2; r++) begin
            msg_cfg[r] = rand_msg(); ins_cfg[r] = 2'($urandom()); nr_cfg[r] = $urandom_range(0, 2);
         end
         run_seq(2'b11, 2'b00, 1'b0, 1'b0);
         check_eq("pair_first", (gnt_order.size() > 0) ? gnt_order[0] : 9, 0);
      end

      // HELLO, ready on first poll, fixed one-cycle ack delay
      slave_delay = 1;
      msg_cfg[0] = "HELLO               ";
      ins_cfg[0] = 2'b00; nr_cfg[0] = 0;
      run_seq(2'b01, 2'b00, 1'b0, 1'b0);
      if (log_q.size() == 7) begin
         check_eq("hello_w0", log_q[1].dat, 32'h48454C4C);
         check_eq("hello_w1", log_q[2].dat, 32'h4F202020);
         check_eq("hello_ins", log_q[6].dat, 32'h1);
      end else begin
         check_eq("hello_len", log_q.size(), 7);
      end
      check_eq("hello_latency", done_cyc[0] - gnt_cyc[0], 20);

      // clear-only on requester 1
      slave_delay = -1;
      msg_cfg[1] = rand_msg(); ins_cfg[1] = 2'b01; nr_cfg[1] = 0;
      run_seq(2'b10, 2'b00, 1'b0, 1'b0);
      check_eq("clear_ins", (log_q.size() == 2) ? log_q[1].dat : 32'hDEAD, 32'h2);

      // three not-ready polls then write with row change
      msg_cfg[0] = rand_msg(); ins_cfg[0] = 2'b10; nr_cfg[0] = 3;
      run_seq(2'b01, 2'b00, 1'b0, 1'b0);
      check_eq("chrow_ins", (log_q.size() == 10) ? log_q[9].dat : 32'hDEAD, 32'h11);

      // poll timeout
      slave_delay = 0;
      msg_cfg[0] = rand_msg(); ins_cfg[0] = 2'b00; nr_cfg[0] = 1000;
      run_seq(2'b01, 2'b00, 1'b1, 1'b0);

      // requester 1 pulses req while requester 0 is being served
      slave_delay = -1;
      msg_cfg[0] = rand_msg(); ins_cfg[0] = 2'b00; nr_cfg[0] = 1;
      run_seq(2'b01, 2'b00, 1'b0, 1'b1);

      // reset during the third DATA write, then restart
      msg_cfg[0] = rand_msg(); ins_cfg[0] = 2'b00; nr_cfg[0] = 0;
      msg0_i = msg_cfg[0]; ins0_i = ins_cfg[0];
      done_cnt = '{0, 0}; err_cnt = '{0, 0};
      req_i = 2'b01;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(posedge clk); #2;
         if (wb_stb_o && wb_we_o && wb_adr_o == BASE + 32'h0C) hit = 1'b1;
      end
      check_eq("rst_hit", hit, 1'b1);
      reset = 1'b0;
      @(posedge clk); #2;
      check_eq("mid_rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, gnt_o, done_o, err_o, busy_o}, 0);
      check_eq("mid_rst_adr", wb_adr_o, 0);
      check_eq("mid_rst_dat", wb_dat_o, 0);
      check_eq("mid_rst_pulses", {done_cnt[0], done_cnt[1], err_cnt[0], err_cnt[1]}, 0);
      reset = 1'b1;
      model_last = 1;
      run_seq(2'b01, 2'b00, 1'b0, 1'b0);

      // randomized traffic
      for (int t = 0; t < 16; t++) begin
         logic [1:0] who, drop;
         who = 2'($urandom_range(1, 3));
         for (int r = 0; r < 2; r++) begin
            msg_cfg[r] = rand_msg(); ins_cfg[r] = 2'($urandom()); nr_cfg[r] = $urandom_range(0, 3);
         end
         drop = 2'($urandom()) & who;
         run_seq(who, drop, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lcd_seq.md
LCD_SEQ -- requirements
Module: lcd_seq

Interface
REQ-001 Parameter BASE_ADR, default 32'hF0010000, LCD peripheral base address.
REQ-002 Parameter POLL_TIMEOUT, default 65535, max cycles spent polling for ready before abort.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req_i  in  2  per-requester request, held high until done_o or err_o for that requester.
REQ-006 msg0_i, msg1_i  in  160 each  20-char message; [159:128] goes to DATA0 … [31:0] goes to DATA4.
REQ-007 ins0_i, ins1_i  in  2 each  bit0 = clear, bit1 = change-row.
REQ-008 gnt_o  out  2  one-hot, high while that requester's sequence runs.
REQ-009 done_o  out  2  one-cycle pulse when the sequence completes.
REQ-010 err_o  out  2  one-cycle pulse when the sequence aborts on poll timeout.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 Wishbone master outputs: wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (32), wb_sel_o (4), wb_dat_o (32).
REQ-013 Wishbone master inputs: wb_dat_i (32), wb_ack_i (1).

Function
REQ-014 Controller FSM states: IDLE, POLL, WR_DATA, WR_INS, FIN.
REQ-015 In IDLE with any req_i high, the controller SHALL grant using round-robin.
- Priority goes to the requester not granted last.
- The last-grant register resets to requester 1, so requester 0 wins the first tie.
REQ-016 At grant, the controller SHALL capture msg and ins into internal registers; later input changes are ignored.
- gnt_o rises on the cycle after the capture edge.
REQ-017 Bus transfer rules:
- wb_cyc_o and wb_stb_o are asserted together and held until the cycle wb_ack_i is sampled high.
- Both are then low for exactly one cycle before the next transfer.
- wb_sel_o = 4'hF on every transfer.
REQ-018 POLL: read BASE_ADR+0x00 (wb_we_o=0).
- On ack with wb_dat_i[0]=1, go to WR_DATA.
- Otherwise re-issue the read after the one-cycle gap.
REQ-019 Poll timeout:
- A counter clears on entry to POLL and increments every cycle in POLL.
- When it reaches POLL_TIMEOUT, drop cyc/stb, pulse err_o for the granted requester, and return to IDLE.
- No write is issued on a timeout.
REQ-020 WR_DATA: write captured words in order to BASE_ADR+0x04, +0x08, +0x0C, +0x10, +0x14 (wb_we_o=1).
- The index counter runs 0..4, then moves to WR_INS.
REQ-021 If captured clear=1, WR_DATA SHALL be skipped; POLL goes directly to WR_INS.
REQ-022 WR_INS: write BASE_ADR+0x18.
- Data = {27'b0, chrow, 2'b00, clear, ~clear}.
- Clear-only gives 0x02; a write gives 0x01; a write plus row change gives 0x11.
REQ-023 FIN: on the cycle after the WR_INS ack:
- Pulse done_o for the granted requester.
- Clear gnt_o.
- Update last-grant.
- Return to IDLE.
REQ-024 Minimum sequence length: a ready-on-first-poll write sequence performs 7 transfers; with single-cycle-delayed ack, each transfer takes 3 cycles.
REQ-025 A requester re-asserting req_i on its done_o cycle is arbitrated normally; if the other requester is pending, the other wins.
REQ-026 A req_i that drops before grant SHALL cause no bus activity.
- A req_i that drops after grant SHALL NOT abort the sequence.
REQ-027 wb_dat_o and wb_adr_o are don't-care while wb_stb_o is low, but SHALL be stable while wb_stb_o is high.

Reset
REQ-028 With reset=0 at a clock edge, all outputs SHALL go to 0 at that edge: cyc, stb, we, adr, sel, dat, gnt, done, err, busy.
- The FSM goes to IDLE and all counters clear.
- Last-grant goes to requester 1.
REQ-029 A reset during a bus transfer SHALL abort it with no done_o or err_o pulse; captured data is discarded.

Verification
REQ-030 Requester 0 only, msg0 = "HELLO" padded with 0x20, ins0=0; slave returns ready on the first poll.
- Required: 1 read at 0xF0010000, then writes 0x48454C4C, 0x4F202020, 0x20202020, 0x20202020, 0x20202020 to 0x04..0x14.
- Then 0x01 to 0xF0010018, then a single done_o[0] pulse.
REQ-031 Both req_i rise on the same cycle.
- Required: requester 0 granted first, done_o[0] pulses, then requester 1 granted, done_o[1] pulses.
- A second simultaneous pair is served 0 then 1 again, because last-grant was 1.
REQ-032 ins1=2'b01 (clear).
- Required: poll, then a single write of 0x02 to 0x18, no DATA writes, done_o[1] pulses.
REQ-033 Slave ready bit held 0 with POLL_TIMEOUT=20.
- Required: err_o pulse 20 cycles after POLL entry, no write transfers, busy_o low the next cycle.
REQ-034 Slave returns not-ready for 3 reads, then ready; ins0=2'b10.
- Required: 4 reads, each separated by a one-cycle stb-low gap, then 5 DATA writes, then INS 0x11.
REQ-035 reset=0 asserted on the cycle stb is high during the third DATA write.
- Required: all outputs 0 the next cycle, no done/err pulse.
- After reset release, a pending req_i restarts the sequence with a poll.
